axi_slave_read_channel: RTL
===========================

AXI_SLAVE_READ_CHANNEL -- requirements
Module: axi_slave_read_channel

Interface
REQ-001 SHALL take parameters, one per line (name, default, meaning):
- ADDR_WIDTH, 32, AR address width.
- READ_CHANNEL_WIDTH, 32, RDATA width (one word per beat).
- READ_BURST_LEN, 8, ARLEN width.
- MEM_ADDR_WIDTH, 10, local memory word-address width.

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ARVALID  in  1  AR valid.
- ARREADY  out  1  AR ready.
- ARADDR  in  ADDR_WIDTH  byte address.
- ARLEN  in  READ_BURST_LEN  beats minus one.
- ARSIZE  in  3  beat size.
- ARBURST  in  2  burst type.
- RVALID  out  1  R valid.
- RREADY  in  1  R ready.
- RDATA  out  READ_CHANNEL_WIDTH  read data.
- RLAST  out  1  last beat.
- RRESP  out  2  response.
- mem_ren  out  1  memory read enable.
- mem_raddr  out  MEM_ADDR_WIDTH  memory word address.
- mem_rdata  in  READ_CHANNEL_WIDTH  memory data, valid the cycle after mem_ren.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-003 State machine SHALL have two states:
- IDLE: ARREADY=1.
- BURST: ARREADY=0.
REQ-004 On ARVALID&&ARREADY in IDLE:
- Latch word address ARADDR[MEM_ADDR_WIDTH+1:2] and ARLEN.
- Set the error flag if ARSIZE!=3'b010 or ARBURST!=2'b01.
- Go to BURST.
REQ-005 Burst SHALL deliver exactly ARLEN+1 beats; ARLEN=255 SHALL give 256 beats, and counters SHALL not overflow.
REQ-006 Word address SHALL increment by 1 per issued read and wrap modulo 2^MEM_ADDR_WIDTH.
REQ-007 Read data SHALL be buffered in a 3-entry FIFO:
- mem_ren=1 only in BURST, only when reads remain to issue, and only when (FIFO occupancy + reads in flight) < 3, using registered counts.
- There SHALL be no combinational path from RREADY to mem_ren.
REQ-008 mem_rdata SHALL be pushed into the FIFO on the edge ending the cycle after mem_ren.
- RVALID = FIFO not empty.
- RDATA, RRESP and RLAST SHALL come from the FIFO head.
REQ-009 Latency and throughput:
- For an AR handshake at edge E0, mem_ren SHALL be 1 in the cycle after E0.
- RVALID SHALL first be 1 two cycles after E0.
- With RREADY held at 1, beats SHALL arrive on consecutive cycles.
REQ-010 While RVALID=1 and RREADY=0, RDATA/RRESP/RLAST SHALL hold stable; no beat SHALL be dropped or duplicated.
REQ-011 RLAST=1 SHALL be asserted only on beat index ARLEN.
REQ-012 The handshake of the RLAST beat SHALL return the block to IDLE; ARREADY=1 in the next cycle.
REQ-013 Error burst (flag set):
- mem_ren SHALL never assert.
- Beats SHALL still be paced through the FIFO at the same timing.
- Every beat SHALL carry RDATA=0 and RRESP=2'b10 (SLVERR).
REQ-014 Non-error beats SHALL carry RRESP=2'b00.
REQ-015 Push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-016 A new AR SHALL not be accepted until the current burst's last beat handshakes.

Reset
REQ-017 When rst_n=0, asynchronously:
- State = IDLE; FIFO and in-flight counts = 0.
- ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RDATA=0, mem_ren=0, mem_raddr=0, busy=0.
REQ-018 ARREADY SHALL rise at the first rising clk edge after rst_n releases.
REQ-019 Reset mid-burst SHALL abandon the burst; no residual beats SHALL appear after release.

Verification
REQ-020 Benches SHALL cover these directed scenarios (stimulus -> required response):
- Single beat: memory word 4=0xDEADBEEF; ARADDR=0x10, ARLEN=0, RREADY=1 -> one beat, RDATA=0xDEADBEEF, RLAST=1, RRESP=00; RVALID 2 cycles after handshake; ARREADY=1 the cycle after.
- Full-rate burst: memory words 0..7 hold 0..7; ARADDR=0, ARLEN=7, RREADY=1 -> 8 beats on 8 consecutive cycles, data 0..7, RLAST only on beat 7.
- Backpressure: ARLEN=3, RREADY pattern 1,0,0,1,0,1,1 -> payload stable while stalled; 4 beats in order, no loss or duplication; occupancy+in-flight never exceeds 3.
- Wrap: MEM_ADDR_WIDTH=4, ARADDR=0x3C, ARLEN=1 -> mem_raddr 15 then 0; data words 15, 0.
- Error: ARSIZE=3'b011, ARLEN=2 -> 3 beats with RRESP=10, RDATA=0, RLAST on the third; mem_ren never asserted.
- Reset mid-burst: rst_n low after beat 2 of an ARLEN=7 burst -> RVALID=0 immediately; ARREADY=1 one edge after release; a following ARLEN=0 read returns correct data.

Source files
------------

// File: rtl/axi_slave_read_channel.sv
// Purpose: AXI4 read-channel slave fronting a 1-cycle-latency word memory through a 3-entry beat FIFO.
// Latency: AR handshake at edge E0 -> mem_ren in the next cycle -> RVALID two cycles after E0.
// Backpressure: RREADY=0 holds the FIFO head; memory reads stop once FIFO occupancy + in-flight reaches 3.
//
// Ports:
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   ARVALID/ARREADY/ARADDR/ARLEN/ARSIZE/ARBURST   AXI read address channel (INCR, 4-byte beats only)
//   RVALID/RREADY/RDATA/RLAST/RRESP               AXI read data channel
//   mem_ren, mem_raddr, mem_rdata  local memory read port (data returns the cycle after mem_ren)
//   busy                           high while a burst is in progress

// Small generic FIFO: registered head, async-reset pointers and count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: a push into a full FIFO is dropped unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok   = pop && (count != '0);
  assign push_ok  = push && ((count != CW'(DEPTH)) || pop_ok);
  assign head_dat = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      store[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module axi_slave_read_channel #(
  parameter int ADDR_WIDTH         = 32,
  parameter int READ_CHANNEL_WIDTH = 32,
  parameter int READ_BURST_LEN     = 8,
  parameter int MEM_ADDR_WIDTH     = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  input  logic [ADDR_WIDTH-1:0]         ARADDR,
  input  logic [READ_BURST_LEN-1:0]     ARLEN,
  input  logic [2:0]                    ARSIZE,
  input  logic [1:0]                    ARBURST,
  output logic                          RVALID,
  input  logic                          RREADY,
  output logic [READ_CHANNEL_WIDTH-1:0] RDATA,
  output logic                          RLAST,
  output logic [1:0]                    RRESP,
  output logic                          mem_ren,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_raddr,
  input  logic [READ_CHANNEL_WIDTH-1:0] mem_rdata,
  output logic                          busy
);
  localparam int FIFO_DEPTH = 3;
  localparam int CNT_W      = READ_BURST_LEN + 1;  // holds ARLEN+1 = 2^READ_BURST_LEN
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [READ_CHANNEL_WIDTH-1:0] data;
    logic [1:0]                    resp;
    logic                          last;
  } beat_t;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                      state;
  logic                        arready_q;
  logic [MEM_ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_W-1:0]            issue_left;
  logic                        err_q;
  logic                        inflight_q;
  logic                        inflight_last_q;
  logic [OCC_W-1:0]            fifo_cnt;
  logic [OCC_W:0]              occ_sum;
  logic                        issue;
  logic                        fifo_vld;
  logic                        rd_pop;
  beat_t                       push_beat;
  beat_t                       head_beat;

  // Only the word-address bits reach memory; the byte offset and high bits are ignored.
  wire unused_araddr_bits = ^{ARADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], ARADDR[1:0]};

  // Slot reservation from registered counts only, so RREADY never reaches mem_ren
  // combinationally. An error burst still "issues" to keep beat pacing identical.
  assign occ_sum = {1'b0, fifo_cnt} + {{OCC_W{1'b0}}, inflight_q};
  assign issue   = (state == BURST) && (issue_left != '0) &&
                   (occ_sum < (OCC_W + 1)'(FIFO_DEPTH));

  assign mem_ren   = issue && !err_q;
  assign mem_raddr = addr_q;
  assign busy      = (state == BURST);
  assign ARREADY   = arready_q;

  always_comb begin
    push_beat      = '0;
    push_beat.data = err_q ? '0 : mem_rdata;
    push_beat.resp = err_q ? 2'b10 : 2'b00;
    push_beat.last = inflight_last_q;
  end

  sync_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_beat_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_q),
    .push_dat (push_beat),
    .pop      (rd_pop),
    .head_dat (head_beat),
    .count    (fifo_cnt)
  );

  assign fifo_vld = (fifo_cnt != '0);
  assign rd_pop   = fifo_vld && RREADY;
  assign RVALID   = fifo_vld;
  // Payload forced to zero while empty so the stale head never shows on the bus.
  assign RDATA    = fifo_vld ? head_beat.data : '0;
  assign RRESP    = fifo_vld ? head_beat.resp : 2'b00;
  assign RLAST    = fifo_vld && head_beat.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      arready_q       <= 1'b0;
      addr_q          <= '0;
      issue_left      <= '0;
      err_q           <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      // Memory data returns one cycle after the read; tag the final read as the last beat.
      inflight_q      <= issue;
      inflight_last_q <= issue && (issue_left == CNT_W'(1));
      case (state)
        IDLE: begin
          arready_q <= 1'b1;
          if (ARVALID && arready_q) begin
            state      <= BURST;
            arready_q  <= 1'b0;
            addr_q     <= ARADDR[MEM_ADDR_WIDTH+1:2];
            issue_left <= {1'b0, ARLEN} + CNT_W'(1);
            err_q      <= (ARSIZE != 3'b010) || (ARBURST != 2'b01);
          end
        end
        BURST: begin
          if (issue) begin
            issue_left <= issue_left - CNT_W'(1);
            if (!err_q) addr_q <= addr_q + MEM_ADDR_WIDTH'(1);
          end
          if (rd_pop && head_beat.last) begin
            state     <= IDLE;
            arready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
